// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin push arbiter with credit-gated FIFO feed
//
// Arbitrates NREQ push requesters onto one downstream shift-register FIFO.
// A credit counter tracks words granted but not yet popped, so grants stop
// at DEPTH and the FIFO can never be pushed while full.
//
// Optional feature: define ARB_LOCK_EN to enable burst locking. While a
// granted requester holds lock[k] (and req[k]) it keeps winning each cycle
// that credits permit. Without the macro the lock port is ignored.
//
// Parameters:
//   WIDTH  data width per requester and FIFO word width
//   DEPTH  downstream FIFO capacity in words
//   NREQ   number of push requesters (2..8)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   req         per-requester push request
//   req_data    requester i word at [i*WIDTH +: WIDTH]
//   lock        per-requester burst-hold request
//   gnt         one-hot combinational grant; word accepted when gnt[i]=1
//   pop_req     consumer pop request
//   fifo_full   FIFO full flag (not needed for gating; credits cover it)
//   fifo_empty  FIFO empty flag
//   fifo_push   registered push strobe to the FIFO
//   fifo_data   registered push word to the FIFO
//   fifo_pop    combinational pop strobe to the FIFO
//   credits     words committed to the FIFO (granted, not yet popped)

module fifo_push_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*WIDTH-1:0]        req_data,
    input  logic [NREQ-1:0]              lock,
    output logic [NREQ-1:0]              gnt,
    input  logic                         pop_req,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    output logic                         fifo_push,
    output logic [WIDTH-1:0]             fifo_data,
    output logic                         fifo_pop,
    output logic [$clog2(DEPTH+1)-1:0]   credits
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(NREQ);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    // Requester index successor, wrapping at NREQ-1 (NREQ need not be a power of two).
    function automatic logic [PW-1:0] f_next_idx(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_credits;
    logic             r_push;
    logic [WIDTH-1:0] r_data;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic [PW-1:0]    w_start;
    logic [PW-1:0]    w_win;
    logic             w_found;
    logic             w_credit_ok;
    logic             w_grant;
    logic             w_dec;
    logic [WIDTH-1:0] w_win_data;
    logic             w_unused_inputs;

`ifdef ARB_LOCK_EN
    logic r_locked;

    // While locked, r_ptr parks on the holder. Once the holder lets go of
    // lock or req, the search begins just past it so round-robin resumes
    // from (k+1) instead of re-favouring k.
    always_comb begin
        w_start = r_ptr;
        if (r_locked && !(req[r_ptr] && lock[r_ptr])) begin
            w_start = f_next_idx(r_ptr);
        end
    end

    // fifo_full is deliberately unused: credit gating already prevents overflow.
    assign w_unused_inputs = fifo_full;
`else
    assign w_start         = r_ptr;
    assign w_unused_inputs = ^{lock, fifo_full};
`endif

    // First asserted request scanning upward from w_start with wrap-around.
    always_comb begin : p_scan
        logic [PW-1:0] v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = w_start;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
            v_idx = f_next_idx(v_idx);
        end
    end

    // A same-cycle pop does not open a slot: grant only below DEPTH.
    assign w_credit_ok = rst && (r_credits < DEPTH_C);
    assign w_grant     = w_found && w_credit_ok;

    always_comb begin
        gnt = '0;
        if (w_grant) begin
            gnt[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PW'(i)) begin
                w_win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_pop = rst && pop_req && !fifo_empty;

    // Guard against a consumer pop with no committed words (cannot occur
    // with a well-behaved FIFO, but keeps the counter from wrapping).
    assign w_dec = fifo_pop && (r_credits != '0);

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
`ifdef ARB_LOCK_EN
            r_ptr <= lock[w_win] ? w_win : f_next_idx(w_win);
`else
            r_ptr <= f_next_idx(w_win);
`endif
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_locked <= 1'b0;
        end else if (w_grant) begin
            r_locked <= lock[w_win];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credits <= '0;
        end else begin
            case ({w_grant, w_dec})
                2'b10:   r_credits <= r_credits + CW'(1);
                2'b01:   r_credits <= r_credits - CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // The push word lags its grant by one cycle; fifo_data holds between pushes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_push <= 1'b0;
            r_data <= '0;
        end else begin
            r_push <= w_grant;
            if (w_grant) begin
                r_data <= w_win_data;
            end
        end
    end

    assign fifo_push = r_push;
    assign fifo_data = r_data;
    assign credits   = r_credits;

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width per requester and FIFO word width.
REQ-002 Parameter DEPTH, default 4, capacity of the downstream shift-register FIFO in words.
REQ-003 Parameter NREQ, default 4, number of push requesters (2..8).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester push request.
REQ-007 req_data  input  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH].
REQ-008 lock  input  NREQ  per-requester burst-hold request (active only with ARB_LOCK_EN).
REQ-009 gnt  output  NREQ  one-hot grant; requester's word is accepted in the cycle gnt[i]=1.
REQ-010 pop_req  input  1  consumer request to pop one word.
REQ-011 fifo_full  input  1  FIFO full flag.
REQ-012 fifo_empty  input  1  FIFO empty flag.
REQ-013 fifo_push  output  1  registered push strobe to FIFO.
REQ-014 fifo_data  output  WIDTH  registered word to FIFO data_in.
REQ-015 fifo_pop  output  1  pop strobe to FIFO.
REQ-016 credits  output  $clog2(DEPTH+1)  words committed to FIFO (granted, not yet popped).

Function
REQ-017 gnt SHALL be combinational from req, registered priority pointer ptr and credits; at most one bit set.
REQ-018 A grant SHALL be issued only when credits < DEPTH; at credits == DEPTH gnt SHALL be 0 even with a same-cycle pop.
REQ-019 Round-robin: winner is the first asserted req at index ptr, ptr+1, ... wrapping modulo NREQ.
REQ-020 After a grant to index k, ptr SHALL become (k+1) mod NREQ next cycle; with no grant ptr SHALL hold.
REQ-021 Cycle after gnt[k]=1: fifo_push=1 and fifo_data=req_data[k]; otherwise fifo_push=0 and fifo_data holds its last value.
REQ-022 fifo_pop SHALL equal pop_req & ~fifo_empty, combinational, zero latency.
REQ-023 credits SHALL increment on a grant, decrement on fifo_pop, and hold when both or neither occur; never exceed DEPTH or underflow.
REQ-024 fifo_push SHALL never be asserted while fifo_full=1; credit gating guarantees this without using fifo_full in grant logic.
REQ-025 Requests withdrawn before grant SHALL be dropped with no side effect.

Reset
REQ-026 With rst=0 at a clock edge: ptr=0, credits=0, fifo_push=0, fifo_data=0, lock state cleared.
REQ-027 While rst=0, gnt SHALL be 0 and fifo_pop SHALL be 0.
REQ-028 A grant made in the cycle reset is sampled SHALL be discarded (no fifo_push the following cycle).
REQ-029 The environment SHALL reset the FIFO in the same cycle; mid-operation reset leaves credits=0 regardless of FIFO contents.

Configuration
REQ-030 Macro ARB_LOCK_EN: when defined, if granted requester k has lock[k]=1, ptr SHALL stay at k so k wins again next cycle while req[k]=1, lock[k]=1 and credits permit.
REQ-031 Lock SHALL release when lock[k] or req[k] drops, after which normal round-robin resumes from (k+1) mod NREQ.
REQ-032 Without ARB_LOCK_EN, the lock port SHALL exist but be ignored; behaviour is pure round-robin.

Verification
REQ-033 Reset, then req=4'b1111 constant, no pops -> grants 0,1,2,3 on consecutive cycles, credits 1..4, then gnt=0 with credits=4.
REQ-034 credits=4, pop_req=1, req=4'b0100 -> fifo_pop=1, no grant that cycle; next cycle credits=3, gnt=4'b0100.
REQ-035 Requester 2 drives 8'hA5 and is granted at cycle t -> fifo_push=1, fifo_data=8'hA5 at t+1; FIFO data_out=8'hA5 when popped first.
REQ-036 credits=2, grant and pop in same cycle -> credits stays 2.
REQ-037 ARB_LOCK_EN defined, req=4'b0011, lock=4'b0001 -> requester 0 granted 4 consecutive cycles until credits=4; drop lock[0] after two pops -> requester 1 granted next.
REQ-038 rst=0 asserted the cycle after three grants -> next cycle credits=0, fifo_push=0, ptr=0; first post-reset grant with req=4'b1111 goes to index 0.
